// File: rtl/tridiag_coeff_loader.sv
// Coefficient loader for the tridiagonal determinant engine: fills b/a/c from a word
// stream, fires the engine, returns its determinant. Optional watchdog: TRIDIAG_LOADER_TIMEOUT_EN.
module tridiag_coeff_loader #(
  parameter int N       = 16,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic [WIDTH*(N-1)-1:0]    a_flat,
  output logic [WIDTH*N-1:0]        b_flat,
  output logic [WIDTH*(N-1)-1:0]    c_flat,
  output logic                      start,
  input  logic                      eng_done,
  input  logic signed [2*WIDTH-1:0] eng_det,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_det,
  output logic                      out_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(3*N-2);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, OUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last_word;
  logic             tmo_hit;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign xfer      = in_valid && in_ready;
  assign last_word = (cnt == CNT_W'(3*N-3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (xfer && last_word) state_nxt = FIRE;
      FIRE: state_nxt = WAIT;
      WAIT: if (eng_done || tmo_hit) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Stream order is b[0..N-1], a[0..N-2], c[0..N-2]; slots are written only while loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_flat <= '0;
      b_flat <= '0;
      c_flat <= '0;
    end else if (xfer) begin
      cnt <= last_word ? '0 : cnt + 1'b1;
      for (int k = 0; k < N; k++)
        if (cnt == CNT_W'(k)) b_flat[k*WIDTH +: WIDTH] <= in_data;
      for (int k = 0; k < N-1; k++) begin
        if (cnt == CNT_W'(N+k))     a_flat[k*WIDTH +: WIDTH] <= in_data;
        if (cnt == CNT_W'(2*N-1+k)) c_flat[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  // Result side: start is high exactly during FIRE, result captured on leaving WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start     <= 1'b0;
      out_valid <= 1'b0;
      out_det   <= '0;
    end else begin
      start <= (state == LOAD) && xfer && last_word;
      if (state == WAIT && eng_done) begin
        out_det   <= eng_det;
        out_valid <= 1'b1;
      end else if (tmo_hit) begin
        out_det   <= '0;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef TRIDIAG_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (state != WAIT) tmo_cnt <= '0;
    else if (!tmo_hit)      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A done arriving on the expiry cycle takes priority over the timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           out_err <= 1'b0;
    else if (state == WAIT && eng_done) out_err <= 1'b0;
    else if (tmo_hit)                   out_err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_tridiag_coeff_loader.sv
// Randomised bench for tridiag_coeff_loader (N=4, WIDTH=16); drives and samples on negedge.
module tb_tridiag_coeff_loader;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int NW  = 3*N-2;
  localparam int TMO = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic [W*(N-1)-1:0]    a_flat;
  logic [W*N-1:0]        b_flat;
  logic [W*(N-1)-1:0]    c_flat;
  logic                  start;
  logic                  eng_done;
  logic signed [2*W-1:0] eng_det;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] out_det;
  logic                  out_err;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] stream [NW];

  tridiag_coeff_loader #(.N(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat), .start(start),
    .eng_done(eng_done), .eng_det(eng_det), .out_valid(out_valid), .out_ready(out_ready),
    .out_det(out_det), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: slots follow word order b, a, c
  function automatic logic [W*N-1:0] model_b();
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = stream[k];
    return r;
  endfunction

  function automatic logic [W*(N-1)-1:0] model_a();
    logic [W*(N-1)-1:0] r;
    for (int k = 0; k < N-1; k++) r[k*W +: W] = stream[N+k];
    return r;
  endfunction

  function automatic logic [W*(N-1)-1:0] model_c();
    logic [W*(N-1)-1:0] r;
    for (int k = 0; k < N-1; k++) r[k*W +: W] = stream[2*N-1+k];
    return r;
  endfunction

  task automatic randomize_stream();
    for (int i = 0; i < NW; i++) stream[i] = W'($urandom);
  endtask

  // Streams all words; ends on the negedge after the last word was taken (FIRE)
  task automatic load_stream(input bit gaps);
    for (int i = 0; i < NW; i++) begin
      while (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        eng_done = 1'($urandom_range(0, 1));
        eng_det  = $urandom;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL load_gap: start=%0b out_valid=%0b, required 0 0", start, out_valid);
        end
      end
      eng_done = 1'b0;
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
      if (i < NW-1) begin
        checks++;
        if (start !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_word%0d: start=%0b in_ready=%0b, required 0 1", i, start, in_ready);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_flats(input string tag);
    checks++;
    if (b_flat !== model_b() || a_flat !== model_a() || c_flat !== model_c()) begin
      errors++;
      $display("FAIL %s_flats: b=%h a=%h c=%h, required b=%h a=%h c=%h",
               tag, b_flat, a_flat, c_flat, model_b(), model_a(), model_c());
    end
  endtask

  // Starts in FIRE; engine answers after a random delay with det
  task automatic run_engine(input logic signed [2*W-1:0] det, input string tag);
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: start=%0b, required 1", tag, start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: start=%0b busy=%0b in_ready=%0b, required 0 1 0", tag, start, busy, in_ready);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    eng_done = 1'b1;
    eng_det  = det;
    @(negedge clk);
    eng_done = 1'b0;
    eng_det  = $urandom;
    checks++;
    if (out_valid !== 1'b1 || out_det !== det || out_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: valid=%0b det=%h err=%0b, required 1 %h 0", tag, out_valid, out_det, out_err, det);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: valid=%0b in_ready=%0b busy=%0b, required 0 1 0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_det !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%0b start=%0b busy=%0b valid=%0b det=%h err=%0b",
               in_ready, start, busy, out_valid, out_det, out_err);
    end
    checks++;
    if (a_flat !== '0 || b_flat !== '0 || c_flat !== '0) begin
      errors++;
      $display("FAIL reset_flats: a=%h b=%h c=%h, required 0", a_flat, b_flat, c_flat);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < NW; i++) stream[i] = (i < N) ? 16'd2 : 16'd1;
    load_stream(1'b0);
    checks++;
    if (b_flat !== 64'h0002000200020002 || a_flat !== 48'h000100010001 || c_flat !== 48'h000100010001) begin
      errors++;
      $display("FAIL basic_flats: b=%h a=%h c=%h", b_flat, a_flat, c_flat);
    end
    run_engine(32'sd5, "basic");
    handshake("basic");
  endtask

  task automatic test_signed();
    for (int i = 0; i < NW; i++) stream[i] = 16'hFFFD;
    load_stream(1'b0);
    checks++;
    if (b_flat !== {4{16'hFFFD}} || a_flat !== {3{16'hFFFD}} || c_flat !== {3{16'hFFFD}}) begin
      errors++;
      $display("FAIL signed_flats: b=%h a=%h c=%h", b_flat, a_flat, c_flat);
    end
    run_engine(-32'sd7, "signed");
    checks++;
    if (out_det !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL signed_det: got %h, required FFFFFFF9", out_det);
    end
    handshake("signed");
  endtask

  task automatic test_backpressure();
    logic signed [2*W-1:0] det;
    randomize_stream();
    det = $urandom;
    load_stream(1'b0);
    run_engine(det, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_det !== det || in_ready !== 1'b0 || start !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b det=%h in_ready=%0b start=%0b, required 1 %h 0 0",
                 i, out_valid, out_det, in_ready, start, det);
      end
    end
    in_valid = 1'b0;
    check_flats("bp");
    handshake("bp");
  endtask

  task automatic test_random_gaps();
    for (int m = 0; m < 4; m++) begin
      randomize_stream();
      load_stream(1'b1);
      check_flats("gaps");
      run_engine($urandom, "gaps");
      handshake("gaps");
    end
  endtask

  task automatic test_reset_mid();
    randomize_stream();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || b_flat !== '0 || a_flat !== '0 || c_flat !== '0) begin
      errors++;
      $display("FAIL rst_load: in_ready=%0b busy=%0b b=%h, required 1 0 0", in_ready, busy, b_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    randomize_stream();
    load_stream(1'b0);
    check_flats("rst_reload");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0 || b_flat !== '0 || a_flat !== '0) begin
      errors++;
      $display("FAIL rst_wait: busy=%0b start=%0b valid=%0b b=%h, required 0 0 0 0", busy, start, out_valid, b_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    eng_done = 1'b1;
    eng_det  = $urandom;
    @(negedge clk);
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_done: valid=%0b busy=%0b, required 0 0", out_valid, busy);
    end
    randomize_stream();
    load_stream(1'b0);
    check_flats("rst_fresh");
    run_engine($urandom, "rst_fresh");
    handshake("rst_fresh");
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 2; m++) begin
      randomize_stream();
      load_stream(1'b0);
      check_flats("b2b");
      run_engine($urandom, "b2b");
      handshake("b2b");
    end
  endtask

`ifdef TRIDIAG_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    logic signed [2*W-1:0] det;
    randomize_stream();
    load_stream(1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != TMO+1 || out_err !== 1'b1 || out_det !== '0) begin
      errors++;
      $display("FAIL timeout: valid=%0b cycles=%0d err=%0b det=%h, required 1 %0d 1 0",
               out_valid, n, out_err, out_det, TMO+1);
    end
    handshake("timeout");
    randomize_stream();
    det = $urandom;
    load_stream(1'b0);
    repeat (TMO) @(negedge clk);
    eng_done = 1'b1;
    eng_det  = det;
    @(negedge clk);
    eng_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || out_det !== det) begin
      errors++;
      $display("FAIL timeout_coincident: valid=%0b err=%0b det=%h, required 1 0 %h", out_valid, out_err, out_det, det);
    end
    handshake("timeout_coincident");
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    eng_done = 1'b0; eng_det = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_random_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef TRIDIAG_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
